song_recorder: RTL and testbench
================================

// Module: song_recorder
// PURPOSE
//  Record-mode counterpart of the play/judge path: captures player key hits (octave, note, length) and writes them as
//  song entries into an internal track RAM instead of reading a stored song. Exposes a 1-cycle read port and committed
//  track length so the playback/scoring side can replay the user's own track as if it were a built-in song.
// PARAMETERS
//  NOTE_KEYS   7   one-hot note keys (do..si)
//  LEN_KEYS    4   length keys; index i -> length code i+1
//  OCT_MAX     2   highest octave code (range 0..OCT_MAX)
//  OCT_DEFAULT 1   octave after reset / at start
//  DEPTH       64  track RAM entries; ADDR_W = clog2(DEPTH) = 6
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous, active-high reset
//  en           in   1          record mode enabled; low aborts an uncommitted take
//  start        in   1          1-cycle pulse: begin new take
//  stop         in   1          1-cycle pulse: commit take
//  undo         in   1          1-cycle pulse: remove last entry
//  hit          in   1          1-cycle pulse: capture current keys as one entry
//  oct_up       in   1          1-cycle pulse: octave +1 (saturating)
//  oct_down     in   1          1-cycle pulse: octave -1 (saturating)
//  note_key     in   NOTE_KEYS  one-hot note; all-zero = rest
//  length_key   in   LEN_KEYS   length select
//  rd_addr      in   ADDR_W     playback read address
//  rd_data      out  8          {octave[1:0], note[2:0], length[2:0]}, registered
//  track_len    out  ADDR_W+1   committed entry count (0..DEPTH)
//  track_valid  out  1          committed track available
//  recording    out  1          high in REC
//  wr_ack       out  1          pulse: entry written this cycle
//  rej          out  1          pulse: hit rejected
//  full         out  1          wr_ptr == DEPTH while in REC
//  octave       out  2          current octave, for display
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=0, track_len=0, track_valid=0, octave=OCT_DEFAULT, rd_data=0, all pulses 0.
//   RAM contents are not cleared.
//  States: IDLE -> REC on start&en (wr_ptr<=0, track_valid<=0, track_len<=0, octave<=OCT_DEFAULT).
//   REC -> COMMIT on stop. COMMIT (1 cycle): track_len<=wr_ptr, track_valid<=(wr_ptr!=0), then IDLE.
//   Any state with en=0 -> IDLE next cycle; uncommitted take discarded (track_valid stays 0).
//   start while in REC restarts the take (same as IDLE->REC).
//  Octave: oct_up/oct_down honoured in every state while en=1; saturate at OCT_MAX / 0.
//   Both asserted in the same cycle: no change.
//  Entry encode on hit in REC: note = 0 if note_key==0, else index+1 of the single set bit.
//   More than one bit set -> rej=1, no write.
//   length = index+1 of the highest set length_key bit; none set -> rej=1, no write.
//   Octave field = octave register value before any same-cycle oct_up/oct_down.
//  Write: valid hit with wr_ptr<DEPTH: RAM[wr_ptr]<=entry, wr_ptr++, wr_ack=1 same edge (registered pulse next cycle).
//  Full: hit with wr_ptr==DEPTH -> rej=1, no write, wr_ptr unchanged.
//  Hit outside REC: ignored silently (no rej).
//  Undo in REC: wr_ptr-- if wr_ptr>0, else no-op.
//  Simultaneous events: undo beats hit (hit gets rej=1).
//   stop with hit: hit is written first, and the commit includes it (track_len = wr_ptr+1).
//   stop with undo: undo applied, then commit.
//  Read: rd_data <= RAM[rd_addr] every cycle, latency 1. Read-during-write to the same address returns the old data.
//  Width rules: wr_ptr and track_len are ADDR_W+1 bits so DEPTH is representable; RAM index uses wr_ptr[ADDR_W-1:0].
// TESTING
//  1. rst, en=1, start; hits note_key=7'b0000100, length_key=4'b0010, oct=1; stop
//     -> RAM[0]=8'b01_011_010, track_len=1, track_valid=1.
//  2. 64 valid hits then a 65th -> full=1, 65th gives rej=1, wr_ptr stays 64;
//     stop -> track_len=64 (7'd64).
//  3. 3 hits, undo, hit, stop -> track_len=3, RAM[2] holds the 4th hit's entry;
//     undo with wr_ptr=0 -> no change.
//  4. note_key=7'b0000011 or length_key=0 on hit -> rej=1, wr_ack=0, wr_ptr unchanged;
//     note_key=0 -> rest entry, note field 3'b000.
//  5. oct_up x3 from 1 -> octave=2; oct_down x4 -> 0; oct_up&oct_down together -> unchanged.
//  6. Mid-take (5 entries) drop en -> IDLE, track_valid=0, track_len=0;
//     rst mid-take -> all outputs at reset values; rd_addr=0 returns entry 0 one cycle later.

Source files
------------

// File: rtl/song_recorder.sv
// song_recorder: captures player key hits (octave, note, length) as 8-bit song
// entries in an internal track RAM. The committed take can be replayed through
// a registered read port, just like a built-in song.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   en              record mode enable; low aborts an uncommitted take
//   start           pulse: begin (or restart) a take
//   stop            pulse: commit the take
//   undo            pulse: drop the last entry
//   hit             pulse: capture current keys as one entry
//   oct_up/oct_down pulses: saturating octave change
//   note_key        one-hot note key (all zero = rest)
//   length_key      length select, highest set bit wins
//   rd_addr         playback read address
//   rd_data         {octave, note, length}, one cycle after rd_addr
//   track_len       committed entry count (0..DEPTH)
//   track_valid     a non-empty take has been committed
//   recording       high while in REC
//   wr_ack          pulse: entry written
//   rej             pulse: hit rejected
//   full            take has DEPTH entries while in REC
//   octave          current octave
module song_recorder #(
    parameter  int unsigned NOTE_KEYS   = 7,
    parameter  int unsigned LEN_KEYS    = 4,
    parameter  int unsigned OCT_MAX     = 2,
    parameter  int unsigned OCT_DEFAULT = 1,
    parameter  int unsigned DEPTH       = 64,
    localparam int unsigned ADDR_W      = $clog2(DEPTH),
    localparam int unsigned PTR_W       = ADDR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 undo,
    input  logic                 hit,
    input  logic                 oct_up,
    input  logic                 oct_down,
    input  logic [NOTE_KEYS-1:0] note_key,
    input  logic [LEN_KEYS-1:0]  length_key,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [7:0]           rd_data,
    output logic [PTR_W-1:0]     track_len,
    output logic                 track_valid,
    output logic                 recording,
    output logic                 wr_ack,
    output logic                 rej,
    output logic                 full,
    output logic [1:0]           octave
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REC    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nx;
    logic [PTR_W-1:0] track_len_nx;
    logic             track_valid_nx;
    logic [1:0]       octave_nx;
    logic             we, wr_ack_nx, rej_nx;

    logic [7:0]       ram [DEPTH];

    logic [3:0]       note_cnt;
    logic [2:0]       note_code, len_code;
    logic             entry_ok;
    logic [7:0]       entry;

    // Key encode: note index+1 of the single set bit, length index+1 of the highest set bit.
    always_comb begin
        note_cnt  = '0;
        note_code = '0;
        len_code  = '0;
        for (int i = 0; i < int'(NOTE_KEYS); i++) begin
            if (note_key[i]) begin
                note_cnt  = note_cnt + 4'd1;
                note_code = 3'(i + 1);
            end
        end
        for (int i = 0; i < int'(LEN_KEYS); i++) begin
            if (length_key[i]) len_code = 3'(i + 1);
        end
        entry_ok = (note_cnt <= 4'd1) && (len_code != 3'd0);
        entry    = {octave, note_code, len_code};
    end

    // Next-state, pointer, commit and pulse logic.
    always_comb begin
        state_nx       = state;
        wr_ptr_nx      = wr_ptr;
        track_len_nx   = track_len;
        track_valid_nx = track_valid;
        octave_nx      = octave;
        we             = 1'b0;
        wr_ack_nx      = 1'b0;
        rej_nx         = 1'b0;

        if (!en) begin
            // Abort: the take in progress is never committed.
            state_nx = IDLE;
        end else begin
            if (oct_up && !oct_down && (octave < 2'(OCT_MAX))) begin
                octave_nx = octave + 2'd1;
            end else if (oct_down && !oct_up && (octave != 2'd0)) begin
                octave_nx = octave - 2'd1;
            end

            unique case (state)
                IDLE, REC: begin
                    if (start) begin
                        state_nx       = REC;
                        wr_ptr_nx      = '0;
                        track_len_nx   = '0;
                        track_valid_nx = 1'b0;
                        octave_nx      = 2'(OCT_DEFAULT);
                    end else if (state == REC) begin
                        // Undo takes priority over a coincident hit.
                        if (undo) begin
                            rej_nx = hit;
                            if (wr_ptr != '0) wr_ptr_nx = wr_ptr - PTR_W'(1);
                        end else if (hit) begin
                            if (!entry_ok || (wr_ptr == PTR_W'(DEPTH))) begin
                                rej_nx = 1'b1;
                            end else begin
                                we        = 1'b1;
                                wr_ack_nx = 1'b1;
                                wr_ptr_nx = wr_ptr + PTR_W'(1);
                            end
                        end
                        // COMMIT samples wr_ptr after this cycle's hit/undo.
                        if (stop) state_nx = COMMIT;
                    end
                end
                COMMIT: begin
                    track_len_nx   = wr_ptr;
                    track_valid_nx = (wr_ptr != '0);
                    state_nx       = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and output registers; recording/full are registered from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            track_len   <= '0;
            track_valid <= 1'b0;
            octave      <= 2'(OCT_DEFAULT);
            wr_ack      <= 1'b0;
            rej         <= 1'b0;
            recording   <= 1'b0;
            full        <= 1'b0;
        end else begin
            state       <= state_nx;
            wr_ptr      <= wr_ptr_nx;
            track_len   <= track_len_nx;
            track_valid <= track_valid_nx;
            octave      <= octave_nx;
            wr_ack      <= wr_ack_nx;
            rej         <= rej_nx;
            recording   <= (state_nx == REC);
            full        <= (state_nx == REC) && (wr_ptr_nx == PTR_W'(DEPTH));
        end
    end

    // Track RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we && !rst) ram[wr_ptr[ADDR_W-1:0]] <= entry;
    end

    // Registered read port; a same-address write returns the old entry.
    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= ram[rd_addr];
    end

endmodule

// File: tb/tb_song_recorder.sv
// Self-checking bench for song_recorder: a behavioural model predicts each
// cycle's pulses and read data, pushes them to scoreboard queues when the
// stimulus is driven, and pops/compares them after the clock edge.
module tb_song_recorder;

    logic       clk = 1'b0;
    logic       rst, en, start, stop, undo, hit, oct_up, oct_down;
    logic [6:0] note_key;
    logic [3:0] length_key;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] track_len;
    logic       track_valid, recording, wr_ack, rej, full;
    logic [1:0] octave;

    always #5 clk = ~clk;

    song_recorder dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .undo(undo),
        .hit(hit), .oct_up(oct_up), .oct_down(oct_down), .note_key(note_key),
        .length_key(length_key), .rd_addr(rd_addr), .rd_data(rd_data),
        .track_len(track_len), .track_valid(track_valid), .recording(recording),
        .wr_ack(wr_ack), .rej(rej), .full(full), .octave(octave)
    );

    typedef enum int {S_IDLE, S_REC, S_COMMIT} mstate_t;

    mstate_t    m_state;
    int         m_ptr, m_len, m_oct;
    bit         m_valid;
    logic [7:0] m_ram   [64];
    bit         m_known [64];

    logic [1:0] resp_q [$];
    logic [8:0] rd_q   [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_pulses();
        start = 0; stop = 0; undo = 0; hit = 0; oct_up = 0; oct_down = 0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_recording"}, 32'(recording), 32'(m_state == S_REC));
        check({tag, "_full"},      32'(full),      32'((m_state == S_REC) && (m_ptr == 64)));
        check({tag, "_octave"},    32'(octave),    32'(m_oct));
        check({tag, "_track_len"}, 32'(track_len), 32'(m_len));
        check({tag, "_valid"},     32'(track_valid), 32'(m_valid));
    endtask

    task automatic do_reset(input string tag);
        clear_pulses();
        rst = 1;
        @(posedge clk); #1;
        m_state = S_IDLE; m_ptr = 0; m_len = 0; m_valid = 0; m_oct = 1;
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_wr_ack"},  32'(wr_ack),  32'd0);
        check({tag, "_rej"},     32'(rej),     32'd0);
        check_status(tag);
        rst = 0;
    endtask

    // One clock of stimulus with model prediction and scoreboard compare.
    task automatic drive(input string tag, input bit st, input bit sp, input bit ud,
                         input bit ht, input bit up, input bit dn,
                         input logic [6:0] nk, input logic [3:0] lk);
        logic [2:0] nf, lf;
        bit         note_ok, ok, ack, rj;
        logic [7:0] ent;
        logic [1:0] r;
        logic [8:0] rq;
        mstate_t    prev;

        rd_q.push_back({1'(m_known[rd_addr]), m_ram[rd_addr]});

        note_ok = 1;
        case (nk)
            7'b0000000: nf = 3'd0;
            7'b0000001: nf = 3'd1;
            7'b0000010: nf = 3'd2;
            7'b0000100: nf = 3'd3;
            7'b0001000: nf = 3'd4;
            7'b0010000: nf = 3'd5;
            7'b0100000: nf = 3'd6;
            7'b1000000: nf = 3'd7;
            default: begin nf = 3'd0; note_ok = 0; end
        endcase
        lf  = lk[3] ? 3'd4 : lk[2] ? 3'd3 : lk[1] ? 3'd2 : lk[0] ? 3'd1 : 3'd0;
        ok  = note_ok && (lf != 3'd0);
        ent = {2'(m_oct), nf, lf};
        ack = 0; rj = 0;
        prev = m_state;

        if (!en) begin
            m_state = S_IDLE;
        end else begin
            if (prev == S_COMMIT) begin
                m_len = m_ptr; m_valid = (m_ptr != 0); m_state = S_IDLE;
            end else if (st) begin
                m_state = S_REC; m_ptr = 0; m_len = 0; m_valid = 0;
            end else if (prev == S_REC) begin
                if (ud) begin
                    rj = ht;
                    if (m_ptr > 0) m_ptr--;
                end else if (ht) begin
                    if (!ok || m_ptr == 64) rj = 1;
                    else begin
                        m_ram[m_ptr] = ent; m_known[m_ptr] = 1; m_ptr++; ack = 1;
                    end
                end
                if (sp) m_state = S_COMMIT;
            end
            if (up && !dn && m_oct < 2) m_oct++;
            else if (dn && !up && m_oct > 0) m_oct--;
            if (st && prev != S_COMMIT) m_oct = 1;
        end
        resp_q.push_back({ack, rj});

        start = st; stop = sp; undo = ud; hit = ht; oct_up = up; oct_down = dn;
        note_key = nk; length_key = lk;
        @(posedge clk); #1;
        clear_pulses();

        r = resp_q.pop_front();
        check({tag, "_wr_ack"}, 32'(wr_ack), 32'(r[1]));
        check({tag, "_rej"},    32'(rej),    32'(r[0]));
        rq = rd_q.pop_front();
        if (rq[8]) check({tag, "_rd_data"}, 32'(rd_data), 32'(rq[7:0]));
        check_status(tag);
    endtask

    task automatic idle(input string tag);
        drive(tag, 0, 0, 0, 0, 0, 0, 7'd0, 4'd0);
    endtask

    task automatic do_hit(input string tag, input logic [6:0] nk, input logic [3:0] lk);
        drive(tag, 0, 0, 0, 1, 0, 0, nk, lk);
    endtask

    task automatic do_start(input string tag);
        drive(tag, 1, 0, 0, 0, 0, 0, 7'd0, 4'd0);
    endtask

    task automatic do_stop(input string tag);
        drive(tag, 0, 1, 0, 0, 0, 0, 7'd0, 4'd0);
        idle({tag, "_commit"});
    endtask

    initial begin
        rst = 1; en = 0; rd_addr = '0; note_key = '0; length_key = '0;
        clear_pulses();
        for (int i = 0; i < 64; i++) m_known[i] = 0;

        do_reset("reset");
        en = 1;

        // Single entry take and its literal encoding.
        do_start("t1_start");
        do_hit("t1_hit", 7'b0000100, 4'b0010);
        do_stop("t1_stop");
        rd_addr = 6'd0;
        idle("t1_read");
        check("t1_entry", 32'(rd_data),     32'(8'b01_011_010));
        check("t1_len",   32'(track_len),   32'd1);
        check("t1_valid", 32'(track_valid), 32'd1);

        // Octave saturation and simultaneous up/down.
        repeat (3) drive("t5_up", 0, 0, 0, 0, 1, 0, 7'd0, 4'd0);
        check("t5_oct_max", 32'(octave), 32'd2);
        repeat (4) drive("t5_down", 0, 0, 0, 0, 0, 1, 7'd0, 4'd0);
        check("t5_oct_min", 32'(octave), 32'd0);
        drive("t5_both0", 0, 0, 0, 0, 1, 1, 7'd0, 4'd0);
        drive("t5_up1", 0, 0, 0, 0, 1, 0, 7'd0, 4'd0);
        drive("t5_both1", 0, 0, 0, 0, 1, 1, 7'd0, 4'd0);
        check("t5_oct_hold", 32'(octave), 32'd1);

        // Malformed keys and rest entry.
        do_start("t4_start");
        do_hit("t4_multi", 7'b0000011, 4'b0010);
        check("t4_multi_rej", 32'(rej), 32'd1);
        do_hit("t4_nolen", 7'b0000100, 4'b0000);
        do_hit("t4_rest", 7'b0000000, 4'b1000);
        do_stop("t4_stop");
        rd_addr = 6'd0;
        idle("t4_read");
        check("t4_rest_entry", 32'(rd_data),   32'(8'b01_000_100));
        check("t4_len",        32'(track_len), 32'd1);

        // Undo, read-during-write, octave field sampled before a same-cycle change.
        do_start("t3_start");
        do_hit("t3_h0", 7'b0000001, 4'b0001);
        drive("t3_h1_up", 0, 0, 0, 1, 1, 0, 7'b0000010, 4'b0100);
        do_hit("t3_h2", 7'b1000000, 4'b1111);
        drive("t3_undo", 0, 0, 1, 0, 0, 0, 7'd0, 4'd0);
        rd_addr = 6'd2;
        do_hit("t3_h3_rdw", 7'b0100000, 4'b0010);
        do_stop("t3_stop");
        check("t3_len", 32'(track_len), 32'd3);
        idle("t3_read2");
        check("t3_ram2", 32'(rd_data), 32'(8'b10_110_010));
        rd_addr = 6'd1;
        idle("t3_read1");
        check("t3_ram1_oct", 32'(rd_data), 32'(8'b01_010_011));

        // Undo at empty take is a no-op.
        do_start("t3b_start");
        drive("t3b_undo0", 0, 0, 1, 0, 0, 0, 7'd0, 4'd0);
        do_hit("t3b_hit", 7'b0001000, 4'b0001);
        do_stop("t3b_stop");
        check("t3b_len", 32'(track_len), 32'd1);

        // Coincident events: undo beats hit, hit with stop is committed, undo with stop.
        do_start("t7_start");
        do_hit("t7_h0", 7'b0010000, 4'b0001);
        drive("t7_undo_hit", 0, 0, 1, 1, 0, 0, 7'b0010000, 4'b0001);
        do_hit("t7_h1", 7'b0000001, 4'b0010);
        drive("t7_hit_stop", 0, 1, 0, 1, 0, 0, 7'b0000010, 4'b0010);
        idle("t7_commit");
        check("t7_len_hit_stop", 32'(track_len), 32'd2);
        do_start("t7b_start");
        do_hit("t7b_h0", 7'b0000001, 4'b0001);
        do_hit("t7b_h1", 7'b0000001, 4'b0001);
        drive("t7b_undo_stop", 0, 1, 1, 0, 0, 0, 7'd0, 4'd0);
        idle("t7b_commit");
        check("t7b_len_undo_stop", 32'(track_len), 32'd1);

        // Fill the RAM, then one more.
        do_start("t2_start");
        for (int i = 0; i < 64; i++) begin
            logic [6:0] nk;
            int         k;
            k  = int'($urandom_range(0, 7));
            nk = (k == 7) ? 7'd0 : 7'(1 << k);
            rd_addr = 6'($urandom_range(0, 63));
            do_hit("t2_fill", nk, 4'($urandom_range(1, 15)));
        end
        check("t2_full", 32'(full), 32'd1);
        do_hit("t2_over", 7'b0000001, 4'b0001);
        check("t2_over_rej", 32'(rej), 32'd1);
        do_stop("t2_stop");
        check("t2_len", 32'(track_len), 32'd64);
        rd_addr = 6'd0;  idle("t2_rd0");
        rd_addr = 6'd31; idle("t2_rd31");
        rd_addr = 6'd63; idle("t2_rd63");

        // Abort by dropping en mid-take.
        do_start("t6_start");
        for (int i = 0; i < 5; i++) do_hit("t6_hit", 7'b0000100, 4'b0001);
        en = 0;
        idle("t6_abort");
        check("t6_valid", 32'(track_valid), 32'd0);
        check("t6_len",   32'(track_len),   32'd0);
        check("t6_rec",   32'(recording),   32'd0);
        en = 1;

        // Reset mid-take; RAM keeps its contents.
        do_start("t6b_start");
        for (int i = 0; i < 5; i++) do_hit("t6b_hit", 7'(1 << i), 4'b0100);
        do_reset("t6b_reset");
        rd_addr = 6'd0;
        idle("t6b_read");
        check("t6b_entry0", 32'(rd_data), 32'(8'b01_001_011));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
